bus_interconnect: RTL



---
 rtl/bus_interconnect.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bus_interconnect.sv
// Single-master to NUM_SLAVES interconnect: address decode, one outstanding
// access, timeout abort and error logging.

module bus_dec_slot #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] mask,
  output logic              hit
);
  assign hit = ((addr & mask) == base);
endmodule

module bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'hBFD003F8, 32'hBA000000, 32'h80400000, 32'h80000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hFFFFFFF8, 32'hFFF00000, 32'hFFC00000, 32'hFFC00000},
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_be,
  input  logic                         m_re,
  input  logic                         m_we,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_stall,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_be,
  output logic                         s_re,
  output logic                         s_we,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [7:0]                   err_count
);
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
    logic                rd;
  } req_t;

  state_t            state, nxt;
  req_t              cur;
  logic [IDX_W-1:0]  idx_q, hit_idx;
  logic [15:0]       cnt;
  logic              err_q, hit_any, req, any, ack, tmo;
  logic              log_err, clr_rd;
  logic [ADDR_W-1:0] log_addr;
  logic [NUM_SLAVES-1:0] hit;

  genvar k;
  generate
    for (k = 0; k < NUM_SLAVES; k++) begin : g_dec
      bus_dec_slot #(.ADDR_W(ADDR_W)) u_dec (
        .addr (m_addr),
        .base (SLAVE_BASE[k*ADDR_W +: ADDR_W]),
        .mask (SLAVE_MASK[k*ADDR_W +: ADDR_W]),
        .hit  (hit[k])
      );
    end
  endgenerate

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign any = m_re | m_we;
  assign req = m_re ^ m_we;
  assign ack = s_ack[idx_q];
  assign tmo = (cnt == TO_LAST);

  always_comb begin
    nxt      = state;
    log_err  = 1'b0;
    log_addr = cur.addr;
    clr_rd   = cur.rd;
    case (state)
      IDLE: if (any) begin
        nxt      = (req && hit_any) ? ACCESS : DONE;
        log_err  = !(req && hit_any);
        log_addr = m_addr;
        clr_rd   = m_re;
      end
      ACCESS: if (ack || tmo) begin
        nxt     = DONE;
        log_err = !ack;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    m_stall = (state == ACCESS) || (state == IDLE && any);
    m_err   = (state == DONE) && err_q;
    s_sel   = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_be    = '0;
    s_re    = 1'b0;
    s_we    = 1'b0;
    if (state == ACCESS) begin
      s_sel   = NUM_SLAVES'(1) << idx_q;
      s_addr  = cur.addr & ~SLAVE_MASK[idx_q*ADDR_W +: ADDR_W];
      s_wdata = cur.wdata;
      s_be    = cur.be;
      s_re    = cur.rd;
      s_we    = !cur.rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur       <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
      m_rdata   <= '0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any) begin
        cur   <= '{addr: m_addr, wdata: m_wdata, be: m_be, rd: m_re};
        idx_q <= hit_idx;
        cnt   <= '0;
        err_q <= log_err;
      end
      if (state == ACCESS) begin
        cnt <= cnt + 16'd1;
        if (ack) begin
          m_rdata <= s_rdata[idx_q*DATA_W +: DATA_W];
          err_q   <= 1'b0;
        end else if (tmo) begin
          err_q <= 1'b1;
        end
      end
      if (log_err) begin
        err_addr <= log_addr;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (clr_rd) m_rdata <= '0;
      end
    end
  end
endmodule
